// File: rtl/wb_stage_p_pkg.sv
// Shared RV opcode and load funct3 encodings for the writeback stage.
package wb_stage_p_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Opcodes that produce a register result; anything unlisted never writes.
  function automatic logic opcode_writes(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: opcode_writes = 1'b1;
      default:                      opcode_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_p_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of a
// naturally aligned read word and sign- or zero-extends it to XLEN.
module load_align
  import wb_stage_p_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  word,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  value
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  // Halfword and word accesses ignore the sub-size offset bits.
  assign off_h  = off & ~OFF_W'(1);
  assign off_w  = off & ~OFF_W'(3);
  assign byte_v = 8'(word >> {off, 3'b000});
  assign half_v = 16'(word >> {off_h, 3'b000});
  assign word_v = 32'(word >> {off_w, 3'b000});

  always_comb begin
    value = XLEN'($signed(word_v));
    case (funct3)
      F3_LB:  value = XLEN'($signed(byte_v));
      F3_LBU: value = XLEN'(byte_v);
      F3_LH:  value = XLEN'($signed(half_v));
      F3_LHU: value = XLEN'(half_v);
      F3_LW:  value = XLEN'($signed(word_v));
      // LWU and LD only exist on RV64; on RV32 they fall back to LW.
      F3_LWU: value = (XLEN == 64) ? XLEN'(word_v) : XLEN'($signed(word_v));
      F3_LD:  value = (XLEN == 64) ? word : XLEN'($signed(word_v));
      default: value = XLEN'($signed(word_v));
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: registers the retiring instruction, selects its result
// source, gates the register-file write and counts retired instructions.
module wb_stage_p
  import wb_stage_p_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mem_vld,
  output logic             o_wb_rdy,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [RA_W-1:0]  i_rd,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_load_word,
  input  logic [XLEN-1:0]  i_pc_plus4,
  output logic             o_rf_wr,
  output logic [RA_W-1:0]  o_rf_rd,
  output logic [XLEN-1:0]  o_rf_data,
  output logic [CNT_W-1:0] o_instret
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic             acc;
  logic             wr_next;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  data_next;
  logic             wr_reg;
  logic [RA_W-1:0]  rd_reg;
  logic [XLEN-1:0]  data_reg;
  logic [CNT_W-1:0] instret_reg;

  assign o_wb_rdy = ~i_stall;
  assign acc      = i_mem_vld & ~i_stall & ~i_flush;

  load_align #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_load_align (
    .word  (i_load_word),
    .off   (i_alu_result[OFF_W-1:0]),
    .funct3(i_funct3),
    .value (load_val)
  );

  // Data is forced to zero whenever the write is suppressed.
  always_comb begin
    wr_next   = opcode_writes(i_opcode) && (i_rd != '0);
    data_next = '0;
    if (wr_next) begin
      case (i_opcode)
        OPC_LOAD:          data_next = load_val;
        OPC_JAL, OPC_JALR: data_next = i_pc_plus4;
        default:           data_next = i_alu_result;
      endcase
    end
  end

  // Flush beats stall; an idle unstalled cycle inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg   <= 1'b0;
      rd_reg   <= '0;
      data_reg <= '0;
    end else if (i_flush || (!i_stall && !i_mem_vld)) begin
      wr_reg   <= 1'b0;
      rd_reg   <= '0;
      data_reg <= '0;
    end else if (acc) begin
      wr_reg   <= wr_next;
      rd_reg   <= i_rd;
      data_reg <= data_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= '0;
    end else if (acc) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign o_rf_wr   = wr_reg;
  assign o_rf_rd   = rd_reg;
  assign o_rf_data = data_reg;
  assign o_instret = instret_reg;

endmodule

// File: doc/wb_stage_p.md
# wb_stage_p

Parametrised writeback stage between the Memory stage and the register-file write port in Decode. It registers the retiring instruction and selects the result source: ALU, aligned and extended load data, or PC+4. It gates the register-file write enable, accepts stall and flush from hazard control, and keeps a retired-instruction counter. It replaces the fixed 32-bit writeback block; load alignment and extension move here from Memory.

## Interface
Parameters:
- `XLEN`, 32, data width; 32 or 64.
- `RA_W`, 5, register-address width.
- `CNT_W`, 64, width of the retire counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_vld`  in  1  Memory stage presents a valid instruction.
- `o_wb_rdy`  out  1  stage accepts this cycle; equals `~i_stall`.
- `i_stall`  in  1  hazard unit freezes this stage.
- `i_flush`  in  1  discard the incoming instruction.
- `i_rd`  in  RA_W  destination register.
- `i_opcode`  in  7  RV opcode.
- `i_funct3`  in  3  load size/sign selector.
- `i_alu_result`  in  XLEN  ALU result; also the load address.
- `i_load_word`  in  XLEN  raw, naturally aligned memory read word.
- `i_pc_plus4`  in  XLEN  link value.
- `o_rf_wr`  out  1  register-file write enable.
- `o_rf_rd`  out  RA_W  write address.
- `o_rf_data`  out  XLEN  write data.
- `o_instret`  out  CNT_W  retired-instruction count.

## Operation
- Accept condition: `acc = i_mem_vld & ~i_stall & ~i_flush`.
- Write enable:
  - Asserted for opcodes LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, only when `i_rd != 0`.
  - Deasserted for BRANCH, STORE, MISC-MEM, SYSTEM and unknown opcodes.
- Result select:
  - LOAD uses the extracted load value.
  - JAL and JALR use `i_pc_plus4`.
  - All other opcodes use `i_alu_result`.
- Load extraction uses byte offset `off = i_alu_result[log2(XLEN/8)-1:0]`.
  - LB (000) and LBU (100): byte at `off`.
  - LH (001) and LHU (101): halfword at `off` with bit 0 ignored.
  - LW (010): word at `off` with low two bits ignored. When XLEN=64, LW sign-extends.
  - LWU (110) and LD (011): valid only when XLEN=64. With XLEN=32 they are treated as LW.
  - Signed forms sign-extend to XLEN; U forms zero-extend.
- Data forcing: when the computed write enable is 0, `o_rf_data` registers zero.
- Pipeline register updates:
  - On `acc`, loads `{wr, rd, data}`.
  - On `i_flush` (with or without valid), loads a bubble `{0, 0, 0}`.
  - When `~i_mem_vld & ~i_stall & ~i_flush`, loads a bubble.
  - When `i_stall` is high and `i_flush` is low, holds its contents.
- Flush priority: flush overrides stall.
- Retire counter:
  - Increments by 1 on every `acc`, including stores and branches.
  - Wraps modulo 2^CNT_W.
  - Never increments on a held (stalled) cycle.

## Timing
- Latency: 1 cycle from accept to `o_rf_*`.
- `o_wb_rdy` is combinational from `i_stall`.
- During a stall, a held `o_rf_wr=1` rewrites the same register each cycle. This is idempotent and intended.
- Asynchronous reset forces `o_rf_wr=0`, `o_rf_rd=0`, `o_rf_data=0` and `o_instret=0` immediately. The first accept is possible on the first rising edge after reset release.
- A reset asserted mid-stall drops the held instruction; no write occurs.
- Simultaneous `i_flush` and `i_stall` produce a bubble on the next edge.

## Structure
- Shared package: RV opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP-IMM, SYSTEM, MISC-MEM) and the funct3 load encodings. The existing opcode macros move into this package.
- Sub-module `load_align`: purely combinational. Takes `(word, off, funct3)` and returns the extended value, parametrised by XLEN. It is unit-tested separately.
- Top level: accept logic, result mux, pipeline register and counter.

## Test plan
- Reset behaviour: reset during traffic → all outputs 0 asynchronously. After release, OP with rd=5 and alu=0x1234 → next cycle `o_rf_wr=1`, rd=5, data=0x1234, `o_instret=1`.
- Load extraction: LB with word 0x80FF7F01 at off=3 → data 0xFFFFFF80. LBU at off=3 → 0x00000080. LH at off=2 → 0xFFFF80FF. LHU at off=1 → 0x00007F01.
- Non-writing instructions: STORE with rd=7 → `o_rf_wr=0`, data 0, counter increments. OP with rd=0 → `o_rf_wr=0`.
- Link value: JAL with pc_plus4=0x104 and rd=1 → data 0x104.
- Stall and flush: stall for 3 cycles after an accepted OP → outputs held and counter unchanged. Flush together with stall and valid → bubble, counter unchanged.
- Counter wrap: with CNT_W=4, 17 accepts → `o_instret=1`.
